// File: rtl/hbm_rd_arbiter.sv
// rtl/hbm_rd_arbiter.sv - round-robin burst read arbiter for one HBM AXI-MM read port
//
// N_REQ requesters share one AXI AR/R channel pair. One burst is in flight
// at a time: a requester is granted in IDLE, its AR is issued in ADDR, and
// R beats are steered to it in DATA until rlast.
//
// Ports:
//   ap_clk, ap_rst                  clock, synchronous active-high reset
//   req_valid/req_ready             per-requester burst request handshake (ready one-hot)
//   req_addr, req_len               packed per-requester start address / AXI length
//   rsp_valid/rsp_ready             per-requester beat handshake (valid one-hot)
//   rsp_data, rsp_last              shared beat payload
//   axi_ar*, axi_r*                 AXI-MM read address / read data channels
//   busy, grant_id                  status: not IDLE, current or last granted index
//   len_err                         sticky burst-length error
//
// Build option: define HBM_ARB_LEN_CHECK_EN to build the beat counter that
// drives len_err; otherwise len_err is tied low.

module hbm_rd_arbiter #(
    parameter  int N_REQ  = 4,
    parameter  int ADDR_W = 64,
    parameter  int DATA_W = 512,
    localparam int GW     = $clog2(N_REQ)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*8-1:0]    req_len,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_last,
    output logic [ADDR_W-1:0]     axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_W-1:0]     axi_rdata,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic                  busy,
    output logic [GW-1:0]         grant_id,
    output logic                  len_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;

    logic                pick_found;
    logic [GW-1:0]       pick_idx;
    logic                beat_acc;

    // Rotating priority: scan from last_grant+1 with wrap, first set bit wins.
    // Requesters that dropped req_valid are naturally skipped.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_grant_q) + i) % N_REQ;
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(cand);
            end
        end
    end

    assign beat_acc = (state_q == S_DATA) && axi_rvalid && rsp_ready[grant_q];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        req_ready    = '0;
        axi_arvalid  = 1'b0;
        axi_araddr   = '0;
        axi_arlen    = '0;
        axi_rready   = 1'b0;
        rsp_valid    = '0;
        rsp_data     = '0;
        rsp_last     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    req_ready[pick_idx] = 1'b1;
                    grant_d             = pick_idx;
                    addr_d              = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    len_d               = req_len[int'(pick_idx)*8 +: 8];
                    state_d             = S_ADDR;
                end
            end
            S_ADDR: begin
                axi_arvalid = 1'b1;
                axi_araddr  = addr_q;
                axi_arlen   = len_q;
                if (axi_arready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Pure pass-through: a requester stall back-pressures the R
                // channel in the same cycle, so no beat buffer is needed.
                rsp_valid[grant_q] = axi_rvalid;
                axi_rready         = rsp_ready[grant_q];
                rsp_data           = axi_rdata;
                rsp_last           = axi_rlast;
                if (beat_acc && axi_rlast) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(N_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;

`ifdef HBM_ARB_LEN_CHECK_EN
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       len_err_q, len_err_d;

    // beat_cnt_q holds the zero-based index of the next beat, so the beat
    // being accepted is the final one exactly when beat_cnt_q == len_q.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        if (state_q == S_ADDR && axi_arready) begin
            beat_cnt_d = '0;
        end else if (beat_acc) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (axi_rlast != (beat_cnt_q == len_q)) begin
                len_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// tb/tb_hbm_rd_arbiter.sv - self-checking bench for hbm_rd_arbiter

module tb_hbm_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int GW = $clog2(N);

`ifdef HBM_ARB_LEN_CHECK_EN
    localparam logic EXP_LEN_ERR = 1'b1;
`else
    localparam logic EXP_LEN_ERR = 1'b0;
`endif

    logic              ap_clk;
    logic              ap_rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*8-1:0]    req_len;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              rsp_last;
    logic [AW-1:0]     axi_araddr;
    logic [7:0]        axi_arlen;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [DW-1:0]     axi_rdata;
    logic              axi_rlast;
    logic              axi_rvalid;
    logic              axi_rready;
    logic              busy;
    logic [GW-1:0]     grant_id;
    logic              len_err;

    hbm_rd_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .busy        (busy),
        .grant_id    (grant_id),
        .len_err     (len_err)
    );

    typedef struct {
        logic [N-1:0]  valid;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t      sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         model_last = N - 1;
    logic [7:0] lens[N];

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int r);
        return 64'h1000 + 64'(r) * 64'h100;
    endfunction

    function automatic logic [N-1:0] onehot(input int r);
        logic [N-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input logic [N-1:0] v);
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = addr_of(i);
            req_len[i*8 +: 8]    = lens[i];
        end
    endtask

    // Drives a request set in IDLE, checks the grant and the AR phase
    // (arready withheld for ar_delay cycles). Returns the expected grantee.
    task automatic grant_phase(input logic [N-1:0] v, input int ar_delay,
                               input logic keep_valid, output int g);
        g = pick(v, model_last);
        set_req(v);
        @(negedge ap_clk);
        n_cmp++;
        if (req_ready !== onehot(g) || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL grant_ready: req_ready=%b busy=%b, required req_ready=%b busy=0",
                     req_ready, busy, onehot(g));
        end
        step();
        if (!keep_valid) req_valid = '0;
        for (int d = 0; d <= ar_delay; d++) begin
            axi_arready = (d == ar_delay);
            @(negedge ap_clk);
            n_cmp++;
            if (axi_arvalid !== 1'b1 || axi_araddr !== addr_of(g) || axi_arlen !== lens[g] ||
                req_ready !== '0 || busy !== 1'b1 || grant_id !== GW'(g)) begin
                n_bad++;
                $display("FAIL addr_phase[%0d]: arvalid=%b araddr=%h arlen=%0d req_ready=%b busy=%b grant_id=%0d, required 1 %h %0d 0 1 %0d",
                         d, axi_arvalid, axi_araddr, axi_arlen, req_ready, busy, grant_id,
                         addr_of(g), lens[g], g);
            end
            step();
        end
        axi_arready = 1'b0;
    endtask

    // Emulator side of the R channel: beats 0..last_at, rlast on last_at,
    // requester g stalls for stall_n cycles before beat stall_at.
    task automatic data_phase(input int g, input int last_at, input int stall_at,
                              input int stall_n, output int nbeats);
        beat_t         e;
        logic [DW-1:0] d;
        nbeats = 0;
        for (int k = 0; k <= last_at; k++) begin
            d = 64'hDA7A_0000_0000_0000 | (64'(g) << 8) | 64'(k);
            axi_rvalid = 1'b1;
            axi_rdata  = d;
            axi_rlast  = (k == last_at);
            if (k == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    rsp_ready = ~onehot(g);
                    @(negedge ap_clk);
                    n_cmp++;
                    if (axi_rready !== 1'b0 || rsp_valid !== onehot(g)) begin
                        n_bad++;
                        $display("FAIL stall[%0d]: axi_rready=%b rsp_valid=%b, required 0 %b",
                                 s, axi_rready, rsp_valid, onehot(g));
                    end
                    step();
                end
            end
            rsp_ready = '1;
            e.valid = onehot(g);
            e.data  = d;
            e.last  = (k == last_at);
            sb_q.push_back(e);
            @(negedge ap_clk);
            n_cmp++;
            if (axi_rready === 1'b1 && rsp_valid !== '0 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (rsp_valid !== e.valid || rsp_data !== e.data || rsp_last !== e.last ||
                    req_ready !== '0) begin
                    n_bad++;
                    $display("FAIL beat[%0d]: rsp_valid=%b data=%h last=%b req_ready=%b, required %b %h %b 0",
                             k, rsp_valid, rsp_data, rsp_last, req_ready, e.valid, e.data, e.last);
                end else begin
                    nbeats++;
                end
            end else begin
                n_bad++;
                $display("FAIL beat_accept[%0d]: axi_rready=%b rsp_valid=%b, required 1 %b",
                         k, axi_rready, rsp_valid, onehot(g));
                sb_q.delete();
            end
            step();
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        model_last = g;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        step();
        step();
        ap_rst = 1'b0;
        @(negedge ap_clk);
        n_cmp++;
        if (busy !== 1'b0 || grant_id !== '0 || req_ready !== '0 || rsp_valid !== '0 ||
            axi_arvalid !== 1'b0 || axi_rready !== 1'b0 || axi_araddr !== '0 ||
            rsp_last !== 1'b0 || len_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: busy=%b grant_id=%0d req_ready=%b rsp_valid=%b arvalid=%b rready=%b araddr=%h last=%b len_err=%b, required all 0",
                     busy, grant_id, req_ready, rsp_valid, axi_arvalid, axi_rready, axi_araddr,
                     rsp_last, len_err);
        end
        step();
    endtask

    task automatic test_single();
        int g, nb;
        lens[0] = 8'd4;
        grant_phase(4'b0001, 0, 1'b0, g);
        data_phase(g, 4, -1, 0, nb);
        @(negedge ap_clk);
        n_cmp++;
        if (nb !== 5) begin
            n_bad++;
            $display("FAIL single_beats: got %0d, required 5", nb);
        end
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== '0 || axi_arvalid !== 1'b0 || grant_id !== '0) begin
            n_bad++;
            $display("FAIL single_idle: busy=%b rsp_valid=%b arvalid=%b grant_id=%0d, required 0 0 0 0",
                     busy, rsp_valid, axi_arvalid, grant_id);
        end
        step();
    endtask

    task automatic test_round_robin();
        int g, nb;
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 0, 1};
        for (int i = 0; i < N; i++) lens[i] = 8'd0;
        for (int r = 0; r < 5; r++) begin
            grant_phase(4'b1111, 0, 1'b1, g);
            n_cmp++;
            if (grant_id !== GW'(exp_seq[r])) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: grant_id=%0d, required %0d", r, grant_id, exp_seq[r]);
            end
            data_phase(g, 0, -1, 0, nb);
            n_cmp++;
            if (nb !== 1) begin
                n_bad++;
                $display("FAIL rr_beats[%0d]: got %0d, required 1", r, nb);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_stall();
        int g, nb;
        lens[1] = 8'd4;
        grant_phase(4'b0010, 0, 1'b0, g);
        data_phase(g, 4, 2, 2, nb);
        n_cmp++;
        if (nb !== 5) begin
            n_bad++;
            $display("FAIL stall_beats: got %0d, required 5", nb);
        end
        step();
    endtask

    task automatic test_arready_delay();
        int g, nb;
        lens[3] = 8'd4;
        grant_phase(4'b1000, 3, 1'b0, g);
        data_phase(g, 4, -1, 0, nb);
        n_cmp++;
        if (nb !== 5) begin
            n_bad++;
            $display("FAIL ardelay_beats: got %0d, required 5", nb);
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        int g, nb;
        lens[2] = 8'd4;
        lens[0] = 8'd4;
        grant_phase(4'b0100, 0, 1'b0, g);
        rsp_ready  = '1;
        axi_rvalid = 1'b1;
        axi_rlast  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            axi_rdata = 64'hBEEF_0000 | 64'(k);
            step();
        end
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        model_last = N - 1;
        @(negedge ap_clk);
        n_cmp++;
        if (busy !== 1'b0 || grant_id !== '0 || rsp_valid !== '0 || rsp_data !== '0 ||
            rsp_last !== 1'b0 || axi_rready !== 1'b0 || axi_arvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b grant_id=%0d rsp_valid=%b data=%h last=%b rready=%b arvalid=%b, required all 0",
                     busy, grant_id, rsp_valid, rsp_data, rsp_last, axi_rready, axi_arvalid);
        end
        axi_rvalid = 1'b0;
        step();
        grant_phase(4'b1111, 0, 1'b0, g);
        n_cmp++;
        if (grant_id !== '0) begin
            n_bad++;
            $display("FAIL reset_regrant: grant_id=%0d, required 0", grant_id);
        end
        data_phase(g, 4, -1, 0, nb);
        step();
    endtask

    task automatic test_len_check();
        int g, nb;
        lens[1] = 8'd4;
        grant_phase(4'b0010, 0, 1'b0, g);
        data_phase(g, 2, -1, 0, nb);
        @(negedge ap_clk);
        n_cmp++;
        if (nb !== 3 || len_err !== EXP_LEN_ERR || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL len_short: beats=%0d len_err=%b busy=%b, required 3 %b 0",
                     nb, len_err, busy, EXP_LEN_ERR);
        end
        step();
        grant_phase(4'b0010, 0, 1'b0, g);
        data_phase(g, 4, -1, 0, nb);
        @(negedge ap_clk);
        n_cmp++;
        if (len_err !== EXP_LEN_ERR) begin
            n_bad++;
            $display("FAIL len_sticky: len_err=%b, required %b", len_err, EXP_LEN_ERR);
        end
        step();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        model_last = N - 1;
        @(negedge ap_clk);
        n_cmp++;
        if (len_err !== 1'b0) begin
            n_bad++;
            $display("FAIL len_clear: len_err=%b, required 0", len_err);
        end
        step();
    endtask

    initial begin
        ap_rst      = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_len     = '0;
        rsp_ready   = '0;
        axi_arready = 1'b0;
        axi_rdata   = '0;
        axi_rlast   = 1'b0;
        axi_rvalid  = 1'b0;
        for (int i = 0; i < N; i++) lens[i] = 8'd0;

        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_arready_delay();
        test_reset_mid_burst();
        test_len_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
